// File: rtl/data_memory.sv
// data_memory: word-addressed data memory with clear sequencer, saturating access counters
// and sticky conflict flag. Optional even-parity protection when DMEM_PARITY_EN is defined.
module data_memory #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    input  logic              clr_req,
    output logic              ready,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
`ifdef DMEM_PARITY_EN
    input  logic              inj_perr,
    output logic              perr,
`endif
    output logic              conflict
);
    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_ready;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic                r_conflict;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    logic w_acc;
    logic w_wr;
    logic w_oe;
    logic w_rd;
    logic w_clr_wr;

    assign w_acc    = (r_state == S_READY);
    assign w_wr     = w_acc && !CEN && !WEN;
    assign w_oe     = w_acc && !CEN && !OEN;
    assign w_rd     = w_oe && WEN;
    // the restart edge itself writes nothing; zeroing resumes from address 0 next edge
    assign w_clr_wr = (r_state == S_CLEAR) && !clr_req;

    // conflict cycles still show the old word, since the array write lands at the edge
    assign Q        = w_oe ? r_mem[A] : '0;
    assign ready    = r_ready;
    assign rd_cnt   = r_rd_cnt;
    assign wr_cnt   = r_wr_cnt;
    assign conflict = r_conflict;

    // clear/ready sequencer: walks every address once, then opens the array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
        end else if (clr_req) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == '1) begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end
    end

    // saturating access counters and sticky conflict flag, untouched by clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (w_wr && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_rd && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_wr && w_oe) r_conflict <= 1'b1;
        end
    end

    // storage array: clear sequencer zeroes, otherwise accepts qualified writes
    always_ff @(posedge clk) begin
        if (w_clr_wr) r_mem[r_clr_addr] <= '0;
        else if (w_wr) r_mem[A] <= D;
    end

`ifdef DMEM_PARITY_EN
    logic r_par [2**ADDR_W];
    logic r_perr;

    assign perr = r_perr;

    // stored even-parity bit per word, optionally corrupted for error injection
    always_ff @(posedge clk) begin
        if (w_clr_wr) r_par[r_clr_addr] <= 1'b0;
        else if (w_wr) r_par[A] <= (^D) ^ inj_perr;
    end

    // sticky parity error on any valid read whose data disagrees with its stored parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_perr <= 1'b0;
        else if (w_rd && ((^r_mem[A]) != r_par[A])) r_perr <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory against a behavioural model.
module tb_data_memory;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        CEN, WEN, OEN, clr_req;
    logic [6:0]  A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        ready, conflict;
    logic [15:0] rd_cnt, wr_cnt;
`ifdef DMEM_PARITY_EN
    logic inj_perr, perr;
    bit   g_inj;
    bit   ref_bad [128];
    bit   m_perr;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [128];
    int          m_busy, m_rd, m_wr;
    bit          m_conf;
    logic [31:0] exp_q [$];

    data_memory dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q),
        .clr_req(clr_req), .ready(ready), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
`ifdef DMEM_PARITY_EN
        .inj_perr(inj_perr), .perr(perr),
`endif
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (ref_mem[i]) ref_mem[i] = '0;
`ifdef DMEM_PARITY_EN
        foreach (ref_bad[i]) ref_bad[i] = 1'b0;
`endif
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; clr_req = 1'b0; A = '0; D = '0;
`ifdef DMEM_PARITY_EN
        inj_perr = 1'b0; g_inj = 1'b0; m_perr = 1'b0;
`endif
        m_busy = 128; m_rd = 0; m_wr = 0; m_conf = 1'b0;
        model_clear();
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_conflict", 32'(conflict), 32'd0);
        chk("rst_q", Q, 32'd0);
`ifdef DMEM_PARITY_EN
        chk("rst_perr", 32'(perr), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // one access cycle: drive, predict, let the edge pass, update model, compare state
    task automatic cyc(input bit cen, input bit wen, input bit oen, input logic [6:0] a,
                       input logic [31:0] d, input bit clr);
        CEN = cen; WEN = wen; OEN = oen; A = a; D = d; clr_req = clr;
`ifdef DMEM_PARITY_EN
        inj_perr = g_inj;
`endif
        chk("ready", 32'(ready), 32'(m_busy == 0));
        if (m_busy == 0 && !cen && !oen) exp_q.push_back(ref_mem[a]);
        @(posedge clk);
        if (m_busy == 0 && !cen) begin
            if (!wen) begin
                ref_mem[a] = d;
                if (m_wr < 65535) m_wr++;
                if (!oen) m_conf = 1'b1;
`ifdef DMEM_PARITY_EN
                ref_bad[a] = g_inj;
`endif
            end else if (!oen) begin
                if (m_rd < 65535) m_rd++;
`ifdef DMEM_PARITY_EN
                if (ref_bad[a]) m_perr = 1'b1;
`endif
            end
        end
        if (clr) begin
            m_busy = 128;
            model_clear();
        end else if (m_busy > 0) m_busy--;
        #1;
        chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
        chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        chk("conflict", 32'(conflict), 32'(m_conf));
`ifdef DMEM_PARITY_EN
        chk("perr", 32'(perr), 32'(m_perr));
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b1, 1'b1, 7'd0, 32'd0, 1'b0);
    endtask

    // monitor: whenever the DUT presents read data, pop the predicted word and compare
    initial begin
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && CEN === 1'b0 && OEN === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL q_unexpected: got %h expected no read at %0t", Q, $time);
                end else chk("q", Q, exp_q.pop_front());
            end else chk("q_idle", Q, 32'd0);
        end
    end

    initial begin
        reset_dut();
        idle(130);
        cyc(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd5, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 7'd127, 32'h1234_5678, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd127, 32'd0, 1'b1);
        idle(128);
        cyc(1'b0, 1'b1, 1'b0, 7'd127, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 7'd3, 32'd1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd3, 32'd0, 1'b0);
        repeat (3000) begin
            cyc(1'($urandom_range(0, 99) >= 80), 1'($urandom), 1'($urandom),
                7'($urandom_range(0, 15)), $urandom, $urandom_range(0, 399) == 0);
        end
        cyc(1'b1, 1'b1, 1'b1, 7'd0, 32'd0, 1'b1);
        idle(20);
        cyc(1'b1, 1'b1, 1'b1, 7'd0, 32'd0, 1'b1);
        idle(40);
        reset_dut();
        idle(129);
`ifdef DMEM_PARITY_EN
        cyc(1'b0, 1'b0, 1'b1, 7'd8, 32'h0000_0007, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd8, 32'd0, 1'b0);
        g_inj = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 7'd9, 32'hA5A5_0001, 1'b0);
        g_inj = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 7'd9, 32'd0, 1'b0);
        idle(5);
        cyc(1'b0, 1'b1, 1'b1, 7'd9, 32'd0, 1'b1);
        idle(130);
        reset_dut();
        idle(129);
`endif
        repeat (70000) cyc(1'b0, 1'b1, 1'b0, 7'($urandom), 32'd0, 1'b0);
        idle(2);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed data memory that sits at the responder end of the core's data-memory port. It samples the active-low `CEN`/`WEN`/`OEN` strobes, the 7-bit word address and write data driven by the processor. It returns read data combinationally so a load completes within the same single cycle. After reset and on request, a built-in clear sequencer zeroes the array. The block also keeps saturating access counters for the verification bench.

## Interface
- `ADDR_W`, 7, word-address width; depth = 2^ADDR_W words
- `DATA_W`, 32, word width
- `CNT_W`, 16, width of each access counter

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `CEN`  in  1  chip enable, active low
- `WEN`  in  1  write enable, active low; qualified by `CEN`
- `OEN`  in  1  output enable, active low; qualified by `CEN`
- `A`  in  ADDR_W  word address
- `D`  in  DATA_W  write data
- `Q`  out  DATA_W  read data (combinational)
- `clr_req`  in  1  one-cycle pulse; restarts the clear sequence
- `ready`  out  1  1 when array is usable (not clearing)
- `rd_cnt`  out  CNT_W  completed reads, saturating
- `wr_cnt`  out  CNT_W  completed writes, saturating
- `conflict`  out  1  sticky: a cycle had `CEN=0`, `WEN=0`, `OEN=0` simultaneously
- `inj_perr`  in  1  parity-injection strobe (present only with `DMEM_PARITY_EN`)
- `perr`  out  1  sticky parity error (present only with `DMEM_PARITY_EN`)

## Operation
- FSM states:
  - CLEAR: `clr_addr` steps 0..2^ADDR_W-1, writing 0 to one word per cycle. After writing the last word it moves to READY.
  - READY: normal accesses.
- `clr_req=1` in READY → CLEAR with `clr_addr=0`. `clr_req` while already in CLEAR restarts at address 0.
- Write: in READY, a write occurs when `CEN=0 && WEN=0`. At the rising edge, `mem[A] <= D` and `wr_cnt` increments.
- Read: in READY, a read is valid when `CEN=0 && OEN=0 && WEN=1`.
  - `Q = mem[A]` combinationally.
  - `rd_cnt` increments at the edge ending that cycle.
- If no valid read, or not READY: `Q = 0`.
- Simultaneous `WEN=0` and `OEN=0` with `CEN=0`:
  - The write is performed.
  - `Q` shows the pre-write contents.
  - The cycle is counted as a write only.
  - `conflict` sets to 1.
- Accesses while in CLEAR are ignored: no array change, no counter change, `Q=0`.
- Counters saturate at 2^CNT_W-1 and never wrap. A clear does not reset the counters or the sticky flags.
- Address is always in range: width equals depth, so there is no out-of-range case.

## Timing
- Reset (async assert, `rst_n=0`):
  - FSM=CLEAR, `clr_addr=0`, `ready=0`.
  - `rd_cnt=0`, `wr_cnt=0`, `conflict=0`, `perr=0`, `Q=0`.
- Release is synchronous to the next edge.
- First READY cycle is 2^ADDR_W cycles after reset release (128 by default).
- `ready` is registered and equals (FSM==READY).
- Reset asserted mid-clear or mid-access aborts immediately; the sequence restarts at address 0.
- Read latency is 0 cycles: `Q` is valid in the same cycle as `A`.
- Write latency is 1 edge: the written data is readable in the following cycle.
- `clr_req` takes effect at the edge it is sampled. `ready` drops in the next cycle, and the access in the `clr_req` cycle itself is still performed.

## Configuration
- Macro: `DMEM_PARITY_EN`.
- Defined:
  - Each word stores an extra even-parity bit, computed from `D` on write. When `inj_perr=1` with a write, the stored parity bit is inverted.
  - On a valid read, parity is checked; a mismatch sets sticky `perr`, which clears only on reset.
  - Clear writes data 0 with parity 0.
- Undefined:
  - No parity storage; the `inj_perr` and `perr` ports are absent.

## Test plan
- Reset release, then hold `CEN=1`: `ready` goes to 1 exactly 128 cycles later; `Q=0` and both counters are 0 throughout.
- Write `D=32'hDEADBEEF` at `A=7'd5`, then read `A=5`: `Q=32'hDEADBEEF` in the read cycle; `wr_cnt=1`, `rd_cnt=1`.
- Write `A=127`, then `clr_req` pulse: `ready=0` for 128 cycles; afterwards a read of `A=127` gives `Q=0`; counters are unchanged.
- Drive `CEN=0`, `WEN=0`, `OEN=0` at `A=3` with `D=32'h1` (old contents 0): `Q=0` that cycle; `mem[3]=1` afterwards; `conflict=1`; `wr_cnt` increments and `rd_cnt` does not.
- Issue 70000 reads: `rd_cnt` saturates at 16'hFFFF and does not wrap.
- With `DMEM_PARITY_EN`: write `A=9` with `inj_perr=1`, then read `A=9`: `perr=1` and stays 1 until `rst_n=0`.
